// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//
// Purpose:
//   Single-outstanding APB requester for two 64-word APB slaves. A request is
//   accepted on a valid/ready handshake, its address is decoded to one of the
//   two slaves, and the APB SETUP -> ACCESS sequence is run on that slave.
//   Completion is reported as a one-cycle rsp_valid pulse with read data and
//   an error flag.
//
//   Address map (ADDR_WIDTH = 8):
//     [5:0] word index inside the slave
//     [6]   slave select (0 = slave1, 1 = slave2)
//     [7]   must be 0; a request with bit 7 set is answered with rsp_err
//           one cycle after acceptance and never reaches the APB bus.
//
// Optional feature:
//   APB_MASTER_TIMEOUT_EN  when defined, an ACCESS phase that sees no PREADY
//                          from the selected slave for TIMEOUT_CYCLES cycles is
//                          abandoned and answered with rsp_err. When undefined,
//                          ACCESS waits for PREADY indefinitely.
//
// Ports:
//   PCLK, PRESET                 clock, asynchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_write/req_addr/req_wdata request direction, address, write data
//   rsp_valid/rsp_rdata/rsp_err  one-cycle completion pulse with data/status
//   PSEL1/PSEL2/PENABLE/PWRITE   APB control towards the two slaves
//   PADDR/PWDATA                 APB address and write data (shared)
//   PRDATA1/PRDATA2              APB read data from each slave
//   PREADY1/PREADY2              APB ready from each slave
// -----------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic                  PSEL1,
    output logic                  PSEL2,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA1,
    input  logic [DATA_WIDTH-1:0] PRDATA2,
    input  logic                  PREADY1,
    input  logic                  PREADY2
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Latched request; held unchanged from SETUP through the end of ACCESS.
    logic [ADDR_WIDTH-1:0] paddr_reg;
    logic [DATA_WIDTH-1:0] pwdata_reg;
    logic                  pwrite_reg;
    logic                  sel_reg;      // 0 = slave1, 1 = slave2

    logic                  rsp_valid_reg, rsp_valid_next;
    logic                  rsp_err_reg,   rsp_err_next;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;

    logic                  accept;
    logic                  decode_err;
    logic                  load_req;
    logic                  timeout_hit;

    // Per-slave views so the selected slave can be picked by sel_reg.
    logic [1:0]            pready_vec;
    logic [DATA_WIDTH-1:0] prdata_arr [2];
    logic [1:0]            psel_vec;
    logic                  pready_sel;
    logic [DATA_WIDTH-1:0] prdata_sel;

    assign pready_vec    = {PREADY2, PREADY1};
    assign prdata_arr[0] = PRDATA1;
    assign prdata_arr[1] = PRDATA2;
    assign pready_sel    = pready_vec[sel_reg];
    assign prdata_sel    = prdata_arr[sel_reg];

    // Gated by PRESET so no request can be taken while reset is held.
    assign req_ready  = (state_reg == ST_IDLE) && !PRESET;
    assign accept     = req_valid && req_ready;
    assign decode_err = req_addr[7];

    // Slave selects decode straight from the state register and the latched
    // select bit, so at most one can ever be high.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_psel
            assign psel_vec[gi] = (state_reg != ST_IDLE) && (sel_reg == 1'(gi));
        end
    endgenerate

    assign PSEL1   = psel_vec[0];
    assign PSEL2   = psel_vec[1];
    assign PENABLE = (state_reg == ST_ACCESS);
    assign PWRITE  = pwrite_reg;
    assign PADDR   = paddr_reg;
    assign PWDATA  = pwdata_reg;

    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_rdata_reg;

    // A zero or negative timeout has no meaningful behaviour; this empty
    // block only exists to make such a configuration visible in elaboration.
    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
        end
    endgenerate

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] timeout_cnt_reg;

    // Counts ACCESS cycles without PREADY. The abort fires in the cycle that
    // would be the TIMEOUT_CYCLES-th miss; a PREADY in that same cycle still
    // wins because the FSM checks pready_sel first.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            timeout_cnt_reg <= '0;
        end else if (state_reg == ST_SETUP) begin
            timeout_cnt_reg <= '0;
        end else if ((state_reg == ST_ACCESS) && !pready_sel) begin
            timeout_cnt_reg <= timeout_cnt_reg + CNT_W'(1);
        end
    end

    assign timeout_hit = (state_reg == ST_ACCESS) && !pready_sel &&
                         (timeout_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and response generation
    always_comb begin
        state_next     = state_reg;
        load_req       = 1'b0;
        rsp_valid_next = 1'b0;
        rsp_err_next   = 1'b0;
        rsp_rdata_next = rsp_rdata_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (decode_err) begin
                        // Answered without touching the bus; stays in IDLE so
                        // the next request can be taken immediately.
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b1;
                        rsp_rdata_next = '0;
                    end else begin
                        load_req   = 1'b1;
                        state_next = ST_SETUP;
                    end
                end
            end

            ST_SETUP: begin
                state_next = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (pready_sel) begin
                    state_next     = ST_IDLE;
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = pwrite_reg ? '0 : prdata_sel;
                end else if (timeout_hit) begin
                    state_next     = ST_IDLE;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    rsp_rdata_next = '0;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request capture and response registers
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            pwrite_reg    <= 1'b0;
            sel_reg       <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            if (load_req) begin
                paddr_reg  <= ADDR_WIDTH'(req_addr[5:0]);
                pwdata_reg <= req_wdata;
                pwrite_reg <= req_write;
                sel_reg    <= req_addr[6];
            end
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
            rsp_rdata_reg <= rsp_rdata_next;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

    logic       PCLK;
    logic       PRESET;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       PSEL1, PSEL2, PENABLE, PWRITE;
    logic [7:0] PADDR, PWDATA;
    logic [7:0] PRDATA1, PRDATA2;
    logic       PREADY1, PREADY2;

    int check_count = 0;
    int error_count = 0;

    apb_master_bridge #(
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL1     (PSEL1),
        .PSEL2     (PSEL2),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA1   (PRDATA1),
        .PRDATA2   (PRDATA2),
        .PREADY1   (PREADY1),
        .PREADY2   (PREADY2)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         delay;      // ACCESS cycles with PREADY low before it rises
        logic [7:0] prdata;
        logic       exp_err;
        logic [7:0] exp_paddr;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act !== exp) begin
            error_count++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // Drive the selected slave; the other one is kept ready with distinct data
    // so any use of the wrong slave's signals shows up.
    task automatic drive_slaves(input logic s, input logic rdy, input logic [7:0] d);
        if (s) begin
            PREADY2 = rdy; PRDATA2 = d; PREADY1 = 1'b1; PRDATA1 = 8'h66;
        end else begin
            PREADY1 = rdy; PRDATA1 = d; PREADY2 = 1'b1; PRDATA2 = 8'h66;
        end
    endtask

    // PSEL1 and PSEL2 must never be high together.
    always @(negedge PCLK) begin
        check_count++;
        if (PSEL1 && PSEL2) begin
            error_count++;
            $display("FAIL psel_overlap actual=11 expected=not-both t=%0t", $time);
        end
    end

    task automatic do_txn(input int idx, input vec_t v);
        logic s;
        s = v.addr[6];
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        // Selected PREADY high before/through SETUP: it must be ignored there.
        drive_slaves(s, 1'b1, 8'hEE);
        check("req_ready_accept", req_ready, 1);
        step();
        req_valid = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        if (v.exp_err) begin
            check("decerr_rsp_valid", rsp_valid, 1);
            check("decerr_rsp_err", rsp_err, 1);
            check("decerr_rsp_rdata", rsp_rdata, 0);
            check("decerr_psel", {PSEL1, PSEL2}, 0);
            check("decerr_req_ready", req_ready, 1);
            $display("txn %0d addr=%02h decode error rsp_err=%0d", idx, v.addr, rsp_err);
            return;
        end
        // SETUP
        check("setup_psel1", PSEL1, !s);
        check("setup_psel2", PSEL2, s);
        check("setup_penable", PENABLE, 0);
        check("setup_paddr", PADDR, v.exp_paddr);
        check("setup_pwdata", PWDATA, v.wdata);
        check("setup_pwrite", PWRITE, v.wr);
        check("setup_rsp_valid", rsp_valid, 0);
        check("setup_req_ready", req_ready, 0);
        step();
        // ACCESS
        for (int i = 0; i <= v.delay; i++) begin
            check("access_penable", PENABLE, 1);
            check("access_psel1", PSEL1, !s);
            check("access_psel2", PSEL2, s);
            check("access_paddr", PADDR, v.exp_paddr);
            check("access_pwdata", PWDATA, v.wdata);
            check("access_pwrite", PWRITE, v.wr);
            check("access_rsp_valid", rsp_valid, 0);
            if (i == v.delay) drive_slaves(s, 1'b1, v.prdata);
            else              drive_slaves(s, 1'b0, 8'hEE);
            step();
        end
        check("done_rsp_valid", rsp_valid, 1);
        check("done_rsp_err", rsp_err, 0);
        check("done_rsp_rdata", rsp_rdata, v.exp_rdata);
        check("done_psel", {PSEL1, PSEL2}, 0);
        check("done_penable", PENABLE, 0);
        check("done_req_ready", req_ready, 1);
        drive_slaves(s, 1'b0, 8'h00);
        $display("txn %0d %s addr=%02h rdata=%02h err=%0d", idx, v.wr ? "WR" : "RD",
                 v.addr, rsp_rdata, rsp_err);
    endtask

    // Asynchronous reset pulse in the middle of a cycle, with checks that the
    // bus drops immediately and no response leaks out afterwards.
    task automatic reset_pulse(input string tag);
        #2;
        PRESET = 1'b1;
        #1;
        check({tag, "_rst_psel"}, {PSEL1, PSEL2}, 0);
        check({tag, "_rst_penable"}, PENABLE, 0);
        check({tag, "_rst_pwrite"}, PWRITE, 0);
        check({tag, "_rst_paddr"}, PADDR, 0);
        check({tag, "_rst_pwdata"}, PWDATA, 0);
        check({tag, "_rst_req_ready"}, req_ready, 0);
        check({tag, "_rst_rsp_valid"}, rsp_valid, 0);
        #3;
        PRESET = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check({tag, "_post_rsp_valid"}, rsp_valid, 0);
            check({tag, "_post_req_ready"}, req_ready, 1);
            step();
        end
        $display("reset %s done", tag);
    endtask

    initial begin
        // Directed vectors with hand-computed expectations. Indices 2..4 run
        // back to back: decode error, then two reads on different slaves.
        vecs[0] = '{1'b0, 8'h45, 8'h00, 0, 8'hA5, 1'b0, 8'h05, 8'hA5};
        vecs[1] = '{1'b1, 8'h12, 8'h3C, 3, 8'h77, 1'b0, 8'h12, 8'h00};
        vecs[2] = '{1'b0, 8'h85, 8'h00, 0, 8'h00, 1'b1, 8'h00, 8'h00};
        vecs[3] = '{1'b0, 8'h01, 8'h00, 0, 8'h5A, 1'b0, 8'h01, 8'h5A};
        vecs[4] = '{1'b0, 8'h41, 8'h00, 1, 8'hC3, 1'b0, 8'h01, 8'hC3};
        vecs[5] = '{1'b1, 8'h7F, 8'h99, 2, 8'h12, 1'b0, 8'h3F, 8'h00};
        vecs[6] = '{1'b1, 8'hFF, 8'h11, 0, 8'h00, 1'b1, 8'h00, 8'h00};
        vecs[7] = '{1'b0, 8'h3F, 8'h00, 3, 8'h81, 1'b0, 8'h3F, 8'h81};

        PRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        PRDATA1   = 8'h00;
        PRDATA2   = 8'h00;
        PREADY1   = 1'b0;
        PREADY2   = 1'b0;
        #2;
        check("reset_req_ready", req_ready, 0);
        check("reset_psel", {PSEL1, PSEL2}, 0);
        check("reset_penable", PENABLE, 0);
        check("reset_pwrite", PWRITE, 0);
        check("reset_paddr", PADDR, 0);
        check("reset_pwdata", PWDATA, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        #10;
        PRESET = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            do_txn(i, vecs[i]);
        end
        step();

        // Slave2 never answers; slave1 is ready and must be ignored.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h41;
        PREADY1   = 1'b1;
        PRDATA1   = 8'h66;
        PREADY2   = 1'b0;
        PRDATA2   = 8'hEE;
        check("stuck_req_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        check("stuck_setup_psel2", PSEL2, 1);
        step();
`ifdef APB_MASTER_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            check("tmo_access_penable", PENABLE, 1);
            check("tmo_access_psel2", PSEL2, 1);
            check("tmo_access_rsp_valid", rsp_valid, 0);
            step();
        end
        check("tmo_psel2", PSEL2, 0);
        check("tmo_penable", PENABLE, 0);
        check("tmo_rsp_valid", rsp_valid, 1);
        check("tmo_rsp_err", rsp_err, 1);
        check("tmo_rsp_rdata", rsp_rdata, 0);
        check("tmo_req_ready", req_ready, 1);
        $display("txn timeout addr=41 err=%0d", rsp_err);
        step();
        check("tmo_rsp_pulse", rsp_valid, 0);
`else
        for (int i = 0; i < 100; i++) begin
            check("wait_access_penable", PENABLE, 1);
            check("wait_access_psel2", PSEL2, 1);
            check("wait_access_rsp_valid", rsp_valid, 0);
            step();
        end
        $display("txn stuck addr=41 still in ACCESS after 100 cycles");
        reset_pulse("stuck");
`endif

        // Reset during ACCESS, then a normal transfer afterwards.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h05;
        PREADY1   = 1'b0;
        PREADY2   = 1'b1;
        check("rst_req_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        step();
        check("rst_pre_penable", PENABLE, 1);
        check("rst_pre_psel1", PSEL1, 1);
        reset_pulse("access");
        do_txn(8, '{1'b0, 8'h05, 8'h00, 1, 8'h3E, 1'b0, 8'h05, 8'h3E});
        step();

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
